// File: rtl/pwm_duty_meter_if.sv
// pwm_duty_meter_if -- signal bundle between a PWM source and the duty meter.
//   pwm_in : raw PWM waveform (asynchronous to clk)
//   clr    : synchronous acquisition abort
//   duty   : last measured high-sample count (R bits, saturated)
//   valid  : one-clk pulse when duty is updated
//   stuck  : input held constant for the timeout interval
// master = PWM source / consumer side, slave = meter side.
interface pwm_duty_meter_if #(
    parameter int R = 8
);
    logic         pwm_in;
    logic         clr;
    logic [R-1:0] duty;
    logic         valid;
    logic         stuck;

    modport master (
        output pwm_in,
        output clr,
        input  duty,
        input  valid,
        input  stuck
    );

    modport slave (
        input  pwm_in,
        input  clr,
        output duty,
        output valid,
        output stuck
    );
endinterface

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter -- measures PWM duty cycle as the number of high samples in a
// window of 2^R sample ticks that starts on a sampled rising edge.
// Parameters:
//   R    : duty resolution in bits (window = 2^R ticks)
//   dvsr : sample-tick divisor, sysclk / (pwm_frq * 2^R); 0 behaves as 1
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : pwm_duty_meter_if.slave (pwm_in, clr in; duty, valid, stuck out)
// Build option:
//   PWM_DUTY_METER_STUCK_DETECT_EN : enables the stuck-input timeout; when
//   undefined, stuck is tied low and the meter waits for an edge forever.
module pwm_duty_meter #(
    parameter int          R    = 8,
    parameter logic [31:0] dvsr = 32'd488
) (
    input  logic                clk,
    input  logic                rst,
    pwm_duty_meter_if.slave     bus
);
    localparam logic [31:0] DVSR_EFF = (dvsr == 32'd0) ? 32'd1 : dvsr;
    localparam logic [R:0]  WIN_LAST = (R+1)'((1 << R) - 1);

    typedef enum logic [1:0] {
        WAIT_EDGE,
        MEASURE,
        UPDATE
    } state_t;

    state_t       state, state_nxt;
    logic         sync1, sync2, smp_q;
    logic [31:0]  pre_cnt;
    logic         tick, rise;
    logic [R:0]   win_cnt, win_nxt;
    logic [R:0]   high_cnt, high_nxt;
    logic         win_done;
    logic         timeout;
    logic [R-1:0] duty_q;
    logic         valid_q;
    logic [R-1:0] duty_sat;

    // Free-running prescaler; clr deliberately has no effect here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + 32'd1;
    end

    assign tick = (pre_cnt == DVSR_EFF - 32'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            smp_q <= 1'b0;
        end else begin
            sync1 <= bus.pwm_in;
            sync2 <= sync1;
            if (tick) smp_q <= sync2;
        end
    end

    // sync2 is the value being sampled on this tick; smp_q is the previous tick's.
    assign rise = tick & sync2 & ~smp_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= WAIT_EDGE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        win_nxt   = win_cnt;
        high_nxt  = high_cnt;
        win_done  = 1'b0;
        if (bus.clr) begin
            state_nxt = WAIT_EDGE;
            win_nxt   = '0;
            high_nxt  = '0;
        end else begin
            case (state)
                WAIT_EDGE: begin
                    if (rise) begin
                        state_nxt = MEASURE;
                        win_nxt   = (R+1)'(1);
                        high_nxt  = (R+1)'(1);
                    end
                end
                MEASURE: begin
                    if (tick) begin
                        win_nxt  = win_cnt + (R+1)'(1);
                        high_nxt = high_cnt + {{R{1'b0}}, sync2};
                        if (win_cnt == WIN_LAST) begin
                            state_nxt = UPDATE;
                            win_done  = 1'b1;
                        end
                    end
                end
                UPDATE:  state_nxt = WAIT_EDGE;
                default: state_nxt = WAIT_EDGE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_cnt  <= '0;
            high_cnt <= '0;
        end else begin
            win_cnt  <= win_nxt;
            high_cnt <= high_nxt;
        end
    end

    // Only a fully-high window reaches 2^R, which sets the top bit.
    assign duty_sat = high_nxt[R] ? '1 : high_nxt[R-1:0];

`ifdef PWM_DUTY_METER_STUCK_DETECT_EN
    localparam logic [R+1:0] TO_LAST = (R+2)'((1 << (R+1)) - 1);

    logic [R+1:0] to_cnt;
    logic         stuck_q;

    assign timeout = !bus.clr && (state == WAIT_EDGE) && tick && !rise &&
                     (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            to_cnt <= '0;
        else if (bus.clr || timeout || rise || state != WAIT_EDGE)
            to_cnt <= '0;
        else if (tick)
            to_cnt <= to_cnt + (R+2)'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          stuck_q <= 1'b0;
        else if (win_done) stuck_q <= 1'b0;
        else if (timeout)  stuck_q <= 1'b1;
    end

    assign bus.stuck = stuck_q;
`else
    assign timeout   = 1'b0;
    assign bus.stuck = 1'b0;
`endif

    // duty/valid are registered on the edge that leaves the completing tick,
    // so valid is high during the single UPDATE clk with duty already loaded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= win_done | timeout;
            if (win_done)     duty_q <= duty_sat;
            else if (timeout) duty_q <= sync2 ? '1 : '0;
        end
    end

    assign bus.duty  = duty_q;
    assign bus.valid = valid_q;
endmodule

// File: doc/pwm_duty_meter.md
PWM_DUTY_METER -- requirements
Module: pwm_duty_meter

Interface
REQ-001 SHALL have parameter R, default 8, duty resolution in bits; measurement window = 2^R sample ticks.
REQ-002 SHALL have parameter dvsr, default 488, 32-bit sample-tick divisor (sysclk / (pwm_frq * 2^R)).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port pwm_in  input  1  asynchronous PWM waveform to be decoded.
REQ-006 SHALL have port clr  input  1  synchronous abort; restarts acquisition.
REQ-007 SHALL have port duty  output  R  last measured high-sample count, saturated to 2^R-1.
REQ-008 SHALL have port valid  output  1  one-clk pulse when duty is updated.
REQ-009 SHALL have port stuck  output  1  input held constant for the timeout interval.

Function
REQ-010 SHALL pass pwm_in through a 2-flop synchronizer before any use.
REQ-011 SHALL run a prescaler counting 0..dvsr-1 and asserting an internal tick for one clk when count = dvsr-1; dvsr = 0 SHALL behave as dvsr = 1 (tick every clk).
REQ-012 SHALL sample the synchronized input only on tick and keep the previous tick sample for edge detection.
REQ-013 SHALL implement FSM states WAIT_EDGE, MEASURE, UPDATE.
REQ-014 WAIT_EDGE: on a tick with sample = 1 and previous sample = 0, SHALL enter MEASURE with win_cnt = 1 and high_cnt = 1.
REQ-015 MEASURE: on each tick, SHALL increment win_cnt and add the sample to high_cnt (R+1 bits); on the tick where win_cnt reaches 2^R, SHALL enter UPDATE.
REQ-016 UPDATE: for exactly one clk, SHALL load duty = min(high_cnt, 2^R-1), pulse valid, clear stuck, then enter WAIT_EDGE.
REQ-017 Latency: valid SHALL assert on the clk immediately following the tick that completes the window.
REQ-018 Rising edges during MEASURE SHALL NOT restart the window.
REQ-019 clr = 1 SHALL force WAIT_EDGE, zero win_cnt, high_cnt and the timeout counter, and suppress valid; duty and stuck SHALL hold.
REQ-020 clr and window completion in the same clk: clr SHALL win; no valid and no duty update.
REQ-021 The prescaler SHALL free-run and SHALL NOT be affected by clr.

Reset
REQ-022 While rst = 0: duty = 0, valid = 0, stuck = 0, FSM = WAIT_EDGE, all counters and synchronizer/sample flops = 0.
REQ-023 Reset asserted mid-measurement SHALL discard the partial window immediately, without a valid pulse.

Configuration
REQ-024 Macro PWM_DUTY_METER_STUCK_DETECT_EN SHALL gate the timeout logic.
REQ-025 With the macro defined: in WAIT_EDGE, a counter SHALL count ticks; on reaching 2^(R+1) ticks with no rising edge, the block SHALL load duty = 2^R-1 if the sample is 1, else 0; SHALL set stuck = 1; SHALL pulse valid; and SHALL restart the count. Entering MEASURE SHALL zero the counter.
REQ-026 Without the macro: no timeout counter; stuck SHALL be tied to 0; the block SHALL wait in WAIT_EDGE indefinitely.

Verification
REQ-027 R=8, dvsr=1, PWM period 256 ticks, 64 high / 192 low -> valid every 256+ clks with duty = 64, stuck = 0.
REQ-028 R=8, dvsr=1, PWM 255 high / 1 low -> duty = 255; PWM 1 high / 255 low -> duty = 1.
REQ-029 R=8, dvsr=4, 50% PWM with 1024-clk period -> ticks every 4 clks; duty = 128; valid width = 1 clk.
REQ-030 Macro defined, pwm_in held 1 for >= 2*512 ticks after reset -> valid with duty = 255, stuck = 1; pwm_in then toggles at 25% -> next valid duty = 64, stuck = 0. Macro undefined, same stimulus -> no valid, stuck = 0.
REQ-031 clr pulsed at window tick 100, and separately on the clk of window completion -> no valid, duty holds its prior value; the next full window reports correctly.
REQ-032 rst driven low mid-MEASURE -> duty = 0, valid = 0 at once; after release, first valid follows the first rising edge plus 256 ticks.
